// File: rtl/axis_i2c_pkg.sv
// Shared types and widths for the AXIS-to-I2C request arbiter.
package axis_i2c_pkg;

    localparam int unsigned AXIS_DATA_WIDTH = 8;
    localparam int unsigned ARB_CNT_WIDTH   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    typedef logic [ARB_CNT_WIDTH-1:0] arb_cnt_t;

    // One stream beat as seen by the downstream I2C master.
    typedef struct packed {
        logic                       tvalid;
        logic [AXIS_DATA_WIDTH-1:0] tdata;
    } axis_beat_t;

endpackage

// File: rtl/axis_rr_pick.sv
// Round-robin requester search: first asserted req after 'last', wrapping.
module axis_rr_pick #(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic [$clog2(N_REQ)-1:0] pick,
    output logic                     valid
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] idx;

    // Lowest rotation distance from 'last' wins; 'last' itself is checked last.
    always_comb begin
        pick  = last;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = IDX_W'((32'(last) + k) % N_REQ);
            if (!valid && req[idx]) begin
                pick  = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_i2c_arb.sv
// Burst-granting round-robin arbiter sharing one I2C master stream between
// N_REQ AXIS requesters, with idle-timeout revocation of a stalled owner.
module axis_i2c_arb
    import axis_i2c_pkg::*;
#(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned BURST_LEN = 3,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_REQ-1:0]                 s_axis_tvalid,
    output logic [N_REQ-1:0]                 s_axis_tready,
    input  logic [N_REQ*AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [N_REQ-1:0]                 grant_o,
    output logic                             busy_o,
    output logic                             timeout_o
);

    localparam int unsigned IDX_W     = $clog2(N_REQ);
    localparam arb_cnt_t    BEAT_LAST = ARB_CNT_WIDTH'(BURST_LEN - 1);
    localparam arb_cnt_t    IDLE_LAST = ARB_CNT_WIDTH'(TIMEOUT - 1);
    localparam arb_cnt_t    CNT_ONE   = ARB_CNT_WIDTH'(1);

    arb_state_t       state_q,   state_d;
    logic [IDX_W-1:0] gidx_q,    gidx_d;
    logic [IDX_W-1:0] last_q,    last_d;
    arb_cnt_t         beat_q,    beat_d;
    arb_cnt_t         idle_q,    idle_d;
    logic [N_REQ-1:0] grant_q,   grant_d;
    logic             busy_q,    busy_d;
    logic             timeout_q, timeout_d;

    logic [IDX_W-1:0]           pick;
    logic                       pick_valid;
    logic [AXIS_DATA_WIDTH-1:0] s_data [N_REQ];
    axis_beat_t                 sel;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign s_data[i] = s_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
    end

    // Current owner's stream, unregistered so data reaches the master in the same cycle.
    assign sel = {s_axis_tvalid[gidx_q], s_data[gidx_q]};

    axis_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req   (s_axis_tvalid),
        .last  (last_q),
        .pick  (pick),
        .valid (pick_valid)
    );

    always_comb begin
        state_d       = state_q;
        gidx_d        = gidx_q;
        last_d        = last_q;
        beat_d        = beat_q;
        idle_d        = idle_q;
        grant_d       = grant_q;
        timeout_d     = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = sel.tdata;
        s_axis_tready = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gidx_d  = pick;
                    grant_d = N_REQ'(1) << pick;
                    state_d = XFER;
                end
            end
            XFER: begin
                m_axis_tvalid         = sel.tvalid;
                s_axis_tready[gidx_q] = m_axis_tready;
                if (sel.tvalid) begin
                    // A valid owner is never idle, even when the master stalls it.
                    idle_d = '0;
                    if (m_axis_tready) begin
                        if (beat_q == BEAT_LAST) begin
                            state_d = IDLE;
                            beat_d  = '0;
                            last_d  = gidx_q;
                            grant_d = '0;
                        end else begin
                            beat_d = beat_q + CNT_ONE;
                        end
                    end
                end else if (idle_q == IDLE_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                    beat_d    = '0;
                    idle_d    = '0;
                    last_d    = gidx_q;
                    grant_d   = '0;
                end else begin
                    idle_d = idle_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d == XFER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gidx_q    <= '0;
            last_q    <= IDX_W'(N_REQ - 1);
            beat_q    <= '0;
            idle_q    <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gidx_q    <= gidx_d;
            last_q    <= last_d;
            beat_q    <= beat_d;
            idle_q    <= idle_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant_o   = grant_q;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_axis_i2c_arb.sv
// Self-checking bench for axis_i2c_arb: two configurations run in lockstep
// against a transaction-level owner/beat/idle model plus directed sequences.
module tb_axis_i2c_arb;
    import axis_i2c_pkg::*;

    localparam int unsigned DW   = AXIS_DATA_WIDTH;
    localparam int unsigned A_N  = 2;
    localparam int unsigned A_BL = 3;
    localparam int unsigned A_TO = 4;
    localparam int unsigned B_N  = 4;
    localparam int unsigned B_BL = 1;
    localparam int unsigned B_TO = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [A_N-1:0]    a_sv, a_sr, a_gr;
    logic [A_N*DW-1:0] a_sd;
    logic              a_mv, a_mr, a_busy, a_to;
    logic [DW-1:0]     a_md;

    logic [B_N-1:0]    b_sv, b_sr, b_gr;
    logic [B_N*DW-1:0] b_sd;
    logic              b_mv, b_mr, b_busy, b_to;
    logic [DW-1:0]     b_md;

    axis_i2c_arb #(.N_REQ(A_N), .BURST_LEN(A_BL), .TIMEOUT(A_TO)) dut_a (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(a_sv), .s_axis_tready(a_sr), .s_axis_tdata(a_sd),
        .m_axis_tvalid(a_mv), .m_axis_tready(a_mr), .m_axis_tdata(a_md),
        .grant_o(a_gr), .busy_o(a_busy), .timeout_o(a_to)
    );

    axis_i2c_arb #(.N_REQ(B_N), .BURST_LEN(B_BL), .TIMEOUT(B_TO)) dut_b (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(b_sv), .s_axis_tready(b_sr), .s_axis_tdata(b_sd),
        .m_axis_tvalid(b_mv), .m_axis_tready(b_mr), .m_axis_tdata(b_md),
        .grant_o(b_gr), .busy_o(b_busy), .timeout_o(b_to)
    );

    // Reference: who owns the master, beats moved, idle run length, last owner.
    typedef struct {
        int owner;
        int beats;
        int idle;
        int last;
        bit tmo;
    } mdl_t;

    mdl_t ma, mb;
    bit   model_ok = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    function automatic mdl_t mdl_next(mdl_t m, int n, int bl, int to, logic r,
                                      logic [7:0] sv, logic mr);
        mdl_t x;
        x = m;
        x.tmo = 1'b0;
        if (r) begin
            x.owner = -1; x.beats = 0; x.idle = 0; x.last = n - 1;
        end else if (m.owner < 0) begin
            for (int k = 1; k <= n; k++) begin
                int i;
                i = (m.last + k) % n;
                if (x.owner < 0 && sv[i]) x.owner = i;
            end
        end else if (sv[m.owner]) begin
            x.idle = 0;
            if (mr) begin
                x.beats = m.beats + 1;
                if (x.beats == bl) begin
                    x.last = m.owner; x.owner = -1; x.beats = 0;
                end
            end
        end else begin
            x.idle = m.idle + 1;
            if (x.idle == to) begin
                x.tmo = 1'b1; x.last = m.owner; x.owner = -1; x.beats = 0; x.idle = 0;
            end
        end
        return x;
    endfunction

    // {grant[8], busy, timeout, m_tvalid, m_tdata[8], s_tready[8]}
    function automatic logic [26:0] mdl_out(mdl_t m, logic [7:0] sv, logic [63:0] sd, logic mr);
        logic [7:0] gr, srd, md;
        logic       mv;
        gr = '0; srd = '0; md = '0; mv = 1'b0;
        if (m.owner >= 0) begin
            gr[m.owner]  = 1'b1;
            mv           = sv[m.owner];
            md           = sd[m.owner*8 +: 8];
            srd[m.owner] = mr;
        end
        return {gr, (m.owner >= 0), m.tmo, mv, md, srd};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic sample();
        logic [26:0] act, exp;
        @(negedge clk);
        if (model_ok) begin
            exp = mdl_out(ma, 8'(a_sv), 64'(a_sd), a_mr);
            act = {8'(a_gr), a_busy, a_to, a_mv, (ma.owner >= 0) ? a_md : 8'h00, 8'(a_sr)};
            chk("model_a", 64'(act), 64'(exp));
            exp = mdl_out(mb, 8'(b_sv), 64'(b_sd), b_mr);
            act = {8'(b_gr), b_busy, b_to, b_mv, (mb.owner >= 0) ? b_md : 8'h00, 8'(b_sr)};
            chk("model_b", 64'(act), 64'(exp));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        ma = mdl_next(ma, A_N, A_BL, A_TO, rst, 8'(a_sv), a_mr);
        mb = mdl_next(mb, B_N, B_BL, B_TO, rst, 8'(b_sv), b_mr);
        if (rst) model_ok = 1'b1;
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic quiet();
        a_sv = '0; a_mr = 1'b1; a_sd = A_N*DW'($urandom);
        b_sv = '0; b_mr = 1'b1; b_sd = B_N*DW'($urandom);
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0] sv;
        logic [7:0] d1;
        logic       mr;
        logic [1:0] e_gr;
        logic       e_mv;
        logic [7:0] e_md;
        logic [1:0] e_sr;
        logic       e_busy;
    } vec_t;

    vec_t tv[10];
    int   exp_alt[12];
    int   exp_rr[10];
    int   exp_tg[6];
    bit   exp_tp[6];
    int   to_seen;
    int   vprob;

    initial begin
        tv[0] = '{2'b10, 8'hA5, 1'b1, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0};
        tv[1] = '{2'b10, 8'hA5, 1'b1, 2'b10, 1'b1, 8'hA5, 2'b10, 1'b1};
        tv[2] = '{2'b10, 8'h5A, 1'b1, 2'b10, 1'b1, 8'h5A, 2'b10, 1'b1};
        tv[3] = '{2'b10, 8'h3C, 1'b1, 2'b10, 1'b1, 8'h3C, 2'b10, 1'b1};
        tv[4] = '{2'b10, 8'h11, 1'b1, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0};
        tv[5] = '{2'b10, 8'h11, 1'b1, 2'b10, 1'b1, 8'h11, 2'b10, 1'b1};
        tv[6] = '{2'b10, 8'h22, 1'b0, 2'b10, 1'b1, 8'h22, 2'b00, 1'b1};
        tv[7] = '{2'b10, 8'h22, 1'b1, 2'b10, 1'b1, 8'h22, 2'b10, 1'b1};
        tv[8] = '{2'b10, 8'h33, 1'b1, 2'b10, 1'b1, 8'h33, 2'b10, 1'b1};
        tv[9] = '{2'b00, 8'h44, 1'b1, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0};
        exp_alt = '{0, 1, 1, 1, 0, 2, 2, 2, 0, 1, 1, 1};
        exp_rr  = '{0, 1, 0, 2, 0, 4, 0, 8, 0, 1};
        exp_tg  = '{1, 1, 1, 1, 0, 2};
        exp_tp  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        quiet();
        do_reset();

        // Reset state
        sample();
        chk("reset_a", {a_gr, a_busy, a_to, a_mv, a_sr}, '0);
        chk("reset_b", {b_gr, b_busy, b_to, b_mv, b_sr}, '0);
        advance();

        // Single active requester s1, table-driven
        do_reset();
        for (int i = 0; i < 10; i++) begin
            a_sv = tv[i].sv;
            a_sd = {tv[i].d1, 8'($urandom)};
            a_mr = tv[i].mr;
            sample();
            chk($sformatf("vec%0d", i),
                {a_gr, a_mv, (tv[i].e_busy ? a_md : 8'h00), a_sr, a_busy},
                {tv[i].e_gr, tv[i].e_mv, tv[i].e_md, tv[i].e_sr, tv[i].e_busy});
            advance();
        end

        // Two continuous requesters alternate with one idle cycle between bursts
        do_reset();
        a_sv = 2'b11;
        for (int i = 0; i < 12; i++) begin
            a_sd = 16'($urandom);
            sample();
            chk($sformatf("alt_grant%0d", i), 64'(a_gr), 64'(exp_alt[i]));
            advance();
        end

        // Owner goes silent after one beat: timeout then hand-over to s1
        do_reset();
        a_sv = 2'b11;
        tick();
        tick();
        a_sv = 2'b10;
        for (int i = 0; i < 6; i++) begin
            sample();
            chk($sformatf("tmo_step%0d", i), {a_to, a_gr}, {exp_tp[i], 2'(exp_tg[i])});
            advance();
        end

        // Long master backpressure must not count as idleness
        do_reset();
        a_sv = 2'b01;
        tick();
        tick();
        a_mr = 1'b0;
        to_seen = 0;
        for (int i = 0; i < 300; i++) begin
            sample();
            if (a_to) to_seen++;
            advance();
        end
        sample();
        chk("stall_no_timeout", 64'(to_seen), 64'd0);
        chk("stall_owner", {a_busy, a_gr}, {1'b1, 2'b01});
        advance();
        a_mr = 1'b1;
        tick();
        tick();
        sample();
        chk("stall_done", {a_busy, a_gr}, {1'b0, 2'b00});
        advance();

        // Reset in the middle of an s1 burst
        do_reset();
        a_sv = 2'b10;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_sv = 2'b11;
        sample();
        chk("rst_mid_abort", {a_mv, a_gr, a_sr, a_busy}, '0);
        advance();
        sample();
        chk("rst_first_grant", 64'(a_gr), 64'd1);
        advance();

        // Single-beat bursts rotate through four requesters
        do_reset();
        b_sv = 4'hF;
        for (int i = 0; i < 10; i++) begin
            b_sd = 32'($urandom);
            sample();
            chk($sformatf("rr4_grant%0d", i), 64'(b_gr), 64'(exp_rr[i]));
            advance();
        end

        // Randomized traffic with occasional resets, checked cycle by cycle
        do_reset();
        vprob = 80;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) vprob = (i % 300 == 0) ? 90 : ((i % 300 == 100) ? 50 : 15);
            rst = ($urandom_range(0, 149) == 0);
            for (int j = 0; j < int'(A_N); j++) a_sv[j] = ($urandom_range(0, 99) < vprob);
            for (int j = 0; j < int'(B_N); j++) b_sv[j] = ($urandom_range(0, 99) < vprob);
            a_sd = 16'($urandom);
            b_sd = 32'($urandom);
            a_mr = ($urandom_range(0, 99) < 75);
            b_mr = ($urandom_range(0, 99) < 75);
            tick();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
